cache_mem_arbiter: RTL and testbench
====================================

Name: cache_mem_arbiter

Overview:
- Shares the single physical memory port between the instruction-side cache miss path and the data-side cache miss path of the pipelined LC-3b CPU.
- Accepts line-sized read requests from the I-cache and read/write requests from the D-cache, grants one at a time, and steers the pmem response back to the owner.
- Sits between the two caches and physical memory.
- Uses fixed D-side priority with a starvation limiter so fetch can always make progress.

Parameters:
- LINE_W, 128, cache line width in bits.
- ADDR_W, 16, byte address width.
- D_STREAK_MAX, 3, max consecutive contested D grants before I is forced to win the next contest (legal range 1..15).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_read  in  1  I-cache line read request; held until i_resp.
- i_address  in  ADDR_W  I-cache line address.
- i_rdata  out  LINE_W  line data to I-cache.
- i_resp  out  1  one-cycle completion pulse to I-cache.
- d_read  in  1  D-cache line read request; held until d_resp.
- d_write  in  1  D-cache line writeback request; held until d_resp.
- d_address  in  ADDR_W  D-cache line address.
- d_wdata  in  LINE_W  writeback data.
- d_rdata  out  LINE_W  line data to D-cache.
- d_resp  out  1  one-cycle completion pulse to D-cache.
- pmem_read  out  1  physical memory read strobe.
- pmem_write  out  1  physical memory write strobe.
- pmem_address  out  ADDR_W  physical memory address.
- pmem_wdata  out  LINE_W  physical memory write data.
- pmem_rdata  in  LINE_W  physical memory read data.
- pmem_resp  in  1  physical memory done pulse.

Behaviour:
- Reset:
  - state=IDLE, streak=0.
  - pmem_read, pmem_write, i_resp, d_resp = 0.
  - pmem_address, pmem_wdata, i_rdata, d_rdata = 0.
- States: IDLE, SERVE_I, SERVE_D, RELEASE.
- IDLE, grant decision:
  - d_req = d_read|d_write.
  - If only d_req: go to SERVE_D.
  - If only i_read: go to SERVE_I.
  - If both and streak<D_STREAK_MAX: go to SERVE_D, streak+=1.
  - If both and streak==D_STREAK_MAX: go to SERVE_I, streak=0.
  - An uncontested grant of either side clears streak to 0.
- On grant, register the address and wdata of the granted requester into pmem_address/pmem_wdata. They stay stable for the entire SERVE state; requester input changes are ignored.
- Strobes:
  - pmem_read/pmem_write are registered Moore outputs.
  - They assert the cycle after the request is first seen in IDLE, so request-to-strobe latency is 1 cycle.
  - SERVE_I drives pmem_read=1.
  - SERVE_D drives pmem_write=d_write latched at grant and pmem_read=!d_write latched.
  - d_read and d_write both high: treated as a write.
- Completion:
  - In SERVE_x, a pmem_resp=1 cycle produces x_resp=1 in the same cycle (combinational) and x_rdata=pmem_rdata (combinational).
  - On the next edge, state goes to RELEASE and the strobes drop to 0.
- x_rdata holds its last delivered value outside resp cycles; it is registered on resp.
- RELEASE lasts one cycle with no grant, giving the requester time to drop its request. Then state goes to IDLE.
- Best-case turnaround:
  - request seen at cycle 0, strobe at cycle 1, resp at cycle k≥1, next grant decision at cycle k+2.
- pmem_resp in IDLE or RELEASE is ignored; no resp is forwarded.
- Exactly one of i_resp/d_resp may be high in any cycle; never both. The non-owner's resp is always 0.
- Requests arriving mid-service are not queued. They are evaluated in IDLE after RELEASE.
- Reset asserted mid-transaction:
  - Next edge: IDLE, strobes 0, streak 0.
  - Any later pmem_resp belonging to the aborted access is ignored.
- streak saturates at D_STREAK_MAX and never wraps.

Test Plan:
- I-only read:
  - Stimulus: i_read=1, i_address=0x1230, pmem_resp after 4 cycles with pmem_rdata=0xA5..A5.
  - Required: pmem_read=1 from cycle 1 with pmem_address=0x1230; i_resp pulses one cycle with i_rdata=0xA5..A5; d_resp stays 0.
- D writeback:
  - Stimulus: d_write=1, d_address=0x4440, d_wdata=0x0123..; change d_address after grant.
  - Required: pmem_write=1, pmem_read=0, pmem_address stays 0x4440; d_resp single pulse.
- Contention and fairness:
  - Stimulus: i_read and d_read held high continuously, pmem_resp latency 2, D_STREAK_MAX=3.
  - Required grant order D,D,D,I,D,D,D,I; no back-to-back resp without a RELEASE cycle between.
- Simultaneous d_read=d_write=1 at 0x0800:
  - Required: pmem_write=1, pmem_read=0.
- Stray pmem_resp:
  - Stimulus: pmem_resp=1 in IDLE and in RELEASE.
  - Required: i_resp=d_resp=0, state unchanged.
- Reset mid-operation:
  - Stimulus: rst=1 while in SERVE_D with pmem_write=1.
  - Required next cycle: pmem_write=0, state IDLE, streak 0.
  - Follow-up: pmem_resp the following cycle produces no d_resp; a new i_read is granted normally.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// Shares one physical memory port between the I-cache and D-cache miss paths.
// The D side wins contests, but a streak limiter forces fetch through periodically.
module cache_mem_arbiter #(
  parameter int LINE_W       = 128,
  parameter int ADDR_W       = 16,
  parameter int D_STREAK_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);
  // state   | meaning
  // IDLE    | no owner; grant decision taken from the current requests
  // SERVE_I | I-cache line read in flight on pmem
  // SERVE_D | D-cache line read or writeback in flight on pmem
  // RELEASE | dead cycle so the finished requester can drop its request
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_I = 2'd1;
  localparam logic [1:0] SERVE_D = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  localparam logic [3:0] STREAK_MAX = 4'(D_STREAK_MAX);

  logic [1:0]        state;
  logic [3:0]        streak;
  logic [LINE_W-1:0] i_rdata_q;
  logic [LINE_W-1:0] d_rdata_q;
  logic              d_req;
  logic              grant_d;
  logic              grant_i;

  always_comb begin
    d_req   = d_read | d_write;
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (d_req && i_read) begin
      grant_d = (streak < STREAK_MAX);
      grant_i = !grant_d;
    end else begin
      grant_d = d_req;
      grant_i = i_read;
    end
  end

  // Response and data are forwarded combinationally in the completion cycle only.
  assign i_resp  = (state == SERVE_I) & pmem_resp;
  assign d_resp  = (state == SERVE_D) & pmem_resp;
  assign i_rdata = i_resp ? pmem_rdata : i_rdata_q;
  assign d_rdata = d_resp ? pmem_rdata : d_rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      streak       <= 4'd0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state        <= SERVE_D;
            pmem_address <= d_address;
            pmem_wdata   <= d_wdata;
            pmem_write   <= d_write;
            pmem_read    <= !d_write;
            streak       <= i_read ? streak + 4'd1 : 4'd0;
          end else if (grant_i) begin
            state        <= SERVE_I;
            pmem_address <= i_address;
            pmem_read    <= 1'b1;
            pmem_write   <= 1'b0;
            streak       <= 4'd0;
          end
        end
        SERVE_I, SERVE_D: begin
          if (pmem_resp) begin
            state      <= RELEASE;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            if (state == SERVE_I) i_rdata_q <= pmem_rdata;
            else                  d_rdata_q <= pmem_rdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: requesters push expected responses,
// a monitor checks grants against the arbitration rules and pops responses.
module tb_cache_mem_arbiter;
  localparam int LW   = 128;
  localparam int AW   = 16;
  localparam int SMAX = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_read = 1'b0, d_read = 1'b0, d_write = 1'b0;
  logic [AW-1:0] i_address = '0, d_address = '0;
  logic [LW-1:0] d_wdata = '0;
  logic [LW-1:0] i_rdata, d_rdata, pmem_wdata;
  logic          i_resp, d_resp, pmem_read, pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_rdata = '0;
  logic          pmem_resp = 1'b0;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.LINE_W(LW), .ADDR_W(AW), .D_STREAK_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  int total = 0;
  int bad   = 0;

  function automatic void check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endfunction

  function automatic logic [LW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [LW-1:0] dflt_line(input logic [AW-1:0] a);
    return {8{a ^ 16'h5a3c}};
  endfunction

  // Physical memory contents (environment) and the reference copy (expectations).
  logic [LW-1:0] pmem_arr [logic [AW-1:0]];
  logic [LW-1:0] ref_arr  [logic [AW-1:0]];

  function automatic logic [LW-1:0] pm_line(input logic [AW-1:0] a);
    return pmem_arr.exists(a) ? pmem_arr[a] : dflt_line(a);
  endfunction

  function automatic logic [LW-1:0] ref_line(input logic [AW-1:0] a);
    return ref_arr.exists(a) ? ref_arr[a] : dflt_line(a);
  endfunction

  typedef struct {bit chk; logic [LW-1:0] data;} dexp_t;
  logic [LW-1:0] iq[$];
  dexp_t         dq[$];
  byte           glog[$];

  // Memory responder: answers an access after 1..4 strobe cycles (or a fixed latency).
  bit mem_auto  = 1'b1;
  int lat_fixed = 0;
  int wait_cnt  = 0;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (mem_auto) begin
        pmem_resp  = 1'b0;
        pmem_rdata = rand_line();
        if (rst || !(pmem_read || pmem_write)) wait_cnt = 0;
        else begin
          if (wait_cnt == 0) wait_cnt = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 4));
          wait_cnt--;
          if (wait_cnt == 0) begin
            pmem_resp = 1'b1;
            if (pmem_write) pmem_arr[pmem_address] = pmem_wdata;
            else            pmem_rdata = pm_line(pmem_address);
          end
        end
      end else wait_cnt = 0;
    end
  end

  // Monitor: grant rules, access stability, response ownership and data.
  logic          p_i = 0, p_d = 0, p_w = 0, p_s = 0, strobe;
  logic [AW-1:0] p_ia, p_da, cur_a;
  logic [LW-1:0] p_wd, cur_wd, last_i = '0, last_d = '0;
  bit            cur_w = 0, rst_prev = 0;
  byte           owner = "?", exp_o, act_o;
  int            m_streak = 0;
  longint        cyc = 0, last_resp = -10;
  dexp_t         de;
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        rst_prev = 1; p_i = 0; p_d = 0; p_s = 0;
        continue;
      end
      if (rst_prev) begin
        rst_prev = 0; m_streak = 0; last_i = '0; last_d = '0; owner = "?";
      end
      strobe = pmem_read | pmem_write;
      if (strobe && !p_s) begin
        if (p_i && p_d) begin
          if (m_streak < SMAX) begin exp_o = "D"; m_streak++; end
          else begin exp_o = "I"; m_streak = 0; end
        end else begin
          exp_o = p_d ? "D" : (p_i ? "I" : "?");
          m_streak = 0;
        end
        act_o = "?";
        if (p_i && pmem_address == p_ia && pmem_read && !pmem_write) act_o = "I";
        if (p_d && pmem_address == p_da && pmem_write == p_w && pmem_read == !p_w &&
            (!p_w || pmem_wdata == p_wd)) act_o = "D";
        check("grant_owner", act_o, exp_o);
        check("grant_gap_ok", (cyc - last_resp >= 3), 1);
        glog.push_back(act_o);
        owner = act_o; cur_a = pmem_address; cur_w = pmem_write; cur_wd = pmem_wdata;
      end else if (strobe) begin
        check("addr_stable", pmem_address, cur_a);
        check("strobe_stable", {pmem_read, pmem_write}, {!cur_w, cur_w});
        if (cur_w) check("wdata_stable", pmem_wdata, cur_wd);
      end
      check("resp_exclusive", i_resp & d_resp, 0);
      check("i_resp", i_resp, strobe && pmem_resp && owner == "I");
      check("d_resp", d_resp, strobe && pmem_resp && owner == "D");
      if (i_resp) begin
        if (iq.size() == 0) begin
          total++; bad++;
          $display("FAIL i_resp_unexpected: got pulse, want none");
        end else check("i_rdata", i_rdata, iq.pop_front());
        last_i = i_rdata; last_resp = cyc;
      end else check("i_rdata_hold", i_rdata, last_i);
      if (d_resp) begin
        if (dq.size() == 0) begin
          total++; bad++;
          $display("FAIL d_resp_unexpected: got pulse, want none");
        end else begin
          de = dq.pop_front();
          if (de.chk) check("d_rdata", d_rdata, de.data);
        end
        last_d = d_rdata; last_resp = cyc;
      end else check("d_rdata_hold", d_rdata, last_d);
      p_i = i_read; p_d = d_read | d_write; p_w = d_write;
      p_ia = i_address; p_da = d_address; p_wd = d_wdata; p_s = strobe;
    end
  end

  // Requester tasks: call at posedge+#1.
  task automatic issue_i(input logic [AW-1:0] a);
    i_address = a; i_read = 1'b1;
    iq.push_back(ref_line(a));
  endtask

  task automatic issue_d(input logic [AW-1:0] a, input bit rd, input bit wr, input logic [LW-1:0] wd);
    d_address = a; d_read = rd; d_write = wr; d_wdata = wd;
    if (wr) begin
      dq.push_back('{chk: 1'b0, data: '0});
      ref_arr[a] = wd;
    end else dq.push_back('{chk: 1'b1, data: ref_line(a)});
  endtask

  task automatic wait_i();
    int n = 0;
    do begin @(negedge clk); n++; end while (!i_resp && n < 100);
    if (!i_resp) begin
      total++; bad++;
      $display("FAIL i_timeout: no i_resp after %0d cycles, want a pulse", n);
    end
    @(posedge clk); #1;
    i_read = 1'b0;
  endtask

  task automatic wait_d();
    int n = 0;
    do begin @(negedge clk); n++; end while (!d_resp && n < 100);
    if (!d_resp) begin
      total++; bad++;
      $display("FAIL d_timeout: no d_resp after %0d cycles, want a pulse", n);
    end
    @(posedge clk); #1;
    d_read = 1'b0; d_write = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic rand_i(input int n, input int maxgap);
    for (int k = 0; k < n; k++) begin
      issue_i({1'b0, 11'($urandom), 4'h0});
      wait_i();
      idle(int'($urandom_range(0, maxgap)));
    end
  endtask

  task automatic rand_d(input int n, input int maxgap);
    for (int k = 0; k < n; k++) begin
      int op = int'($urandom_range(0, 2));
      issue_d({1'b1, 8'h00, 3'($urandom), 4'h0}, op != 1, op != 0, rand_line());
      wait_d();
      idle(int'($urandom_range(0, maxgap)));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1, "watchdog");
  end

  string exp_order = "DDDIDDDI";
  logic [LW-1:0] wline;

  initial begin
    idle(2);
    @(negedge clk);
    check("rst_pmem_read", pmem_read, 0);
    check("rst_pmem_write", pmem_write, 0);
    check("rst_i_resp", i_resp, 0);
    check("rst_d_resp", d_resp, 0);
    check("rst_pmem_address", pmem_address, 0);
    check("rst_pmem_wdata", pmem_wdata, 0);
    check("rst_i_rdata", i_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    @(posedge clk); #1; rst = 1'b0;
    idle(2);

    // I-only read with A5 line, latency 4
    pmem_arr[16'h1230] = {16{8'hA5}};
    ref_arr[16'h1230]  = {16{8'hA5}};
    lat_fixed = 4;
    issue_i(16'h1230);
    @(negedge clk);
    check("i_strobe_c0", pmem_read, 0);
    @(negedge clk);
    check("i_strobe_c1", pmem_read, 1);
    check("i_addr_c1", pmem_address, 16'h1230);
    wait_i();
    idle(2);

    // D writeback, address and data scrambled after the grant, then read back
    wline = 128'h0123_4567_89ab_cdef_0123_4567_89ab_cdef;
    issue_d(16'h4440, 1'b0, 1'b1, wline);
    @(negedge clk); @(negedge clk);
    check("dw_pmem_write", pmem_write, 1);
    check("dw_pmem_read", pmem_read, 0);
    @(posedge clk); #1;
    d_address = 16'h7770; d_wdata = rand_line();
    @(negedge clk);
    check("dw_addr_held", pmem_address, 16'h4440);
    wait_d();
    idle(1);
    issue_d(16'h4440, 1'b1, 1'b0, '0);
    wait_d();
    idle(1);

    // d_read and d_write together is a write
    issue_d(16'h0800, 1'b1, 1'b1, rand_line());
    @(negedge clk); @(negedge clk);
    check("rw_pmem_write", pmem_write, 1);
    check("rw_pmem_read", pmem_read, 0);
    check("rw_addr", pmem_address, 16'h0800);
    wait_d();
    idle(2);

    // Stray pmem_resp in IDLE and in RELEASE
    mem_auto = 1'b0;
    pmem_resp = 1'b1; pmem_rdata = rand_line();
    @(negedge clk);
    check("stray_idle_i_resp", i_resp, 0);
    check("stray_idle_d_resp", d_resp, 0);
    @(posedge clk); #1; pmem_resp = 1'b0;
    @(negedge clk);
    check("stray_idle_no_strobe", pmem_read | pmem_write, 0);
    @(posedge clk); #1;
    issue_i(16'h2460);
    @(posedge clk); #1;
    pmem_resp = 1'b1; pmem_rdata = pm_line(16'h2460);
    @(negedge clk);
    check("manual_i_resp", i_resp, 1);
    @(posedge clk); #1;
    i_read = 1'b0; pmem_rdata = rand_line();
    @(negedge clk);
    check("stray_release_i_resp", i_resp, 0);
    check("stray_release_d_resp", d_resp, 0);
    @(posedge clk); #1; pmem_resp = 1'b0;
    @(negedge clk);
    check("stray_release_no_strobe", pmem_read | pmem_write, 0);
    @(posedge clk); #1;
    mem_auto = 1'b1; lat_fixed = 0;
    idle(1);

    // Randomized mixed traffic
    fork
      rand_i(40, 3);
      rand_d(40, 3);
    join
    idle(3);

    // Reset during a contested D writeback
    issue_d(16'h8010, 1'b1, 1'b0, '0);
    wait_d();
    idle(2);
    mem_auto = 1'b0;
    issue_i(16'h0440);
    issue_d(16'h8020, 1'b0, 1'b1, rand_line());
    @(negedge clk); @(negedge clk);
    check("pre_rst_pmem_write", pmem_write, 1);
    @(posedge clk); #1;
    rst = 1'b1; i_read = 1'b0; d_write = 1'b0;
    iq.delete(); dq.delete();
    @(posedge clk); #1;
    rst = 1'b0; pmem_resp = 1'b1; pmem_rdata = rand_line();
    @(negedge clk);
    check("post_rst_pmem_write", pmem_write, 0);
    check("post_rst_pmem_read", pmem_read, 0);
    check("post_rst_no_d_resp", d_resp, 0);
    @(posedge clk); #1;
    pmem_resp = 1'b0; mem_auto = 1'b1;

    // Continuous contention with latency 2: streak must restart from zero
    lat_fixed = 2;
    glog.delete();
    fork
      rand_i(2, 0);
      rand_d(6, 0);
    join
    check("grant_count", glog.size(), 8);
    for (int k = 0; k < 8 && k < glog.size(); k++)
      check($sformatf("grant_order_%0d", k), glog[k], exp_order[k]);
    idle(3);
    check("iq_drained", iq.size(), 0);
    check("dq_drained", dq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
